// File: rtl/bsg_cache_pkg.sv
// Shared types for the cache-side AXI helpers: the memory-slave FSM states
// and the AXI response encoding it returns.
package bsg_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } bsg_cache_axi_mem_state_e;

  localparam logic [1:0] axi_resp_okay = 2'b00;

endpackage

// File: rtl/bsg_cache_axi_mem_array.sv
// Word array behind the AXI memory slave: one byte-masked write port and one
// asynchronous read port. Contents are deliberately left unreset.
module bsg_cache_axi_mem_array #(
  parameter int els_p       = 2048,
  parameter int width_p     = 32,
  parameter int idx_width_p = 11
) (
  input  logic                   clk_i,
  input  logic                   w_v_i,
  input  logic [idx_width_p-1:0] w_idx_i,
  input  logic [width_p-1:0]     w_data_i,
  input  logic [width_p/8-1:0]   w_mask_i,
  input  logic [idx_width_p-1:0] r_idx_i,
  output logic [width_p-1:0]     r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int b = 0; b < width_p/8; b++) begin
        if (w_mask_i[b]) mem[w_idx_i][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

  assign r_data_o = mem[r_idx_i];

endmodule

// File: rtl/bsg_cache_axi_mem.sv
// AXI4 memory slave for cache DMA traffic: serves one INCR burst at a time from
// a per-cache region of an internal array, alternating AW/AR on contention.
module bsg_cache_axi_mem
  import bsg_cache_pkg::*;
#(
  parameter int addr_width_p        = 32,
  parameter int num_cache_p         = 2,
  parameter int axi_id_width_p      = 6,
  parameter int axi_data_width_p    = 32,
  parameter int axi_burst_len_p     = 4,
  parameter int mem_els_per_cache_p = 1024,
  localparam int lg_num_cache_lp    = (num_cache_p > 1) ? $clog2(num_cache_p) : 1,
  localparam int strb_width_lp      = axi_data_width_p/8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [axi_id_width_p-1:0]   axi_awid_i,
  input  logic [addr_width_p-1:0]     axi_awaddr_addr_i,
  input  logic [lg_num_cache_lp-1:0]  axi_awaddr_cache_id_i,
  input  logic [7:0]                  axi_awlen_i,
  input  logic                        axi_awvalid_i,
  output logic                        axi_awready_o,

  input  logic [axi_data_width_p-1:0] axi_wdata_i,
  input  logic [strb_width_lp-1:0]    axi_wstrb_i,
  input  logic                        axi_wlast_i,
  input  logic                        axi_wvalid_i,
  output logic                        axi_wready_o,

  output logic [axi_id_width_p-1:0]   axi_bid_o,
  output logic [1:0]                  axi_bresp_o,
  output logic                        axi_bvalid_o,
  input  logic                        axi_bready_i,

  input  logic [axi_id_width_p-1:0]   axi_arid_i,
  input  logic [addr_width_p-1:0]     axi_araddr_addr_i,
  input  logic [lg_num_cache_lp-1:0]  axi_araddr_cache_id_i,
  input  logic [7:0]                  axi_arlen_i,
  input  logic                        axi_arvalid_i,
  output logic                        axi_arready_o,

  output logic [axi_id_width_p-1:0]   axi_rid_o,
  output logic [axi_data_width_p-1:0] axi_rdata_o,
  output logic [1:0]                  axi_rresp_o,
  output logic                        axi_rlast_o,
  output logic                        axi_rvalid_o,
  input  logic                        axi_rready_i,

  output logic                        proto_err_o
);

  localparam int lg_strb_lp   = $clog2(strb_width_lp);
  localparam int lg_els_lp    = $clog2(mem_els_per_cache_p);
  localparam int idx_width_lp = lg_num_cache_lp + lg_els_lp;
  localparam logic [7:0] exp_len_lp = 8'(axi_burst_len_p - 1);

  bsg_cache_axi_mem_state_e  state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [7:0]                len_q, len_d;
  logic [axi_id_width_p-1:0] id_q, id_d;
  logic [lg_num_cache_lp-1:0] cache_q, cache_d;
  logic [lg_els_lp-1:0]      word_q, word_d;
  logic                      last_write_q, last_write_d;
  logic                      proto_err_q, proto_err_d;

  logic                      aw_grant, ar_grant, w_fire, is_last;
  logic [lg_els_lp-1:0]      offset;
  logic [idx_width_lp-1:0]   mem_idx;
  logic [axi_data_width_p-1:0] mem_rdata;

  // Contention alternates: last_write_q=1 means the previous grant was a write,
  // so a simultaneous AR wins next. Out of reset a write wins.
  assign aw_grant = reset_n_i && (state_q == IDLE) && axi_awvalid_i
                    && (!axi_arvalid_i || !last_write_q);
  assign ar_grant = reset_n_i && (state_q == IDLE) && axi_arvalid_i && !aw_grant;
  assign w_fire   = (state_q == WDATA) && axi_wvalid_i;
  assign is_last  = (cnt_q == len_q);

  // Offset arithmetic is lg_els_lp wide, so bursts wrap inside their own region.
  assign offset  = word_q + lg_els_lp'(cnt_q);
  assign mem_idx = {cache_q, offset};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    id_d         = id_q;
    cache_d      = cache_q;
    word_d       = word_q;
    last_write_d = last_write_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      IDLE: begin
        if (aw_grant) begin
          state_d      = WDATA;
          id_d         = axi_awid_i;
          cache_d      = axi_awaddr_cache_id_i;
          word_d       = lg_els_lp'(axi_awaddr_addr_i >> lg_strb_lp);
          len_d        = axi_awlen_i;
          cnt_d        = '0;
          last_write_d = 1'b1;
          if (axi_awlen_i != exp_len_lp) proto_err_d = 1'b1;
        end else if (ar_grant) begin
          state_d      = RDATA;
          id_d         = axi_arid_i;
          cache_d      = axi_araddr_cache_id_i;
          word_d       = lg_els_lp'(axi_araddr_addr_i >> lg_strb_lp);
          len_d        = axi_arlen_i;
          cnt_d        = '0;
          last_write_d = 1'b0;
          if (axi_arlen_i != exp_len_lp) proto_err_d = 1'b1;
        end
      end
      WDATA: begin
        if (w_fire) begin
          cnt_d = cnt_q + 8'd1;
          if (axi_wlast_i != is_last) proto_err_d = 1'b1;
          if (is_last) state_d = WRESP;
        end
      end
      WRESP: begin
        if (axi_bready_i) state_d = IDLE;
      end
      RDATA: begin
        if (axi_rready_i) begin
          cnt_d = cnt_q + 8'd1;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      id_q         <= '0;
      cache_q      <= '0;
      word_q       <= '0;
      last_write_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      id_q         <= id_d;
      cache_q      <= cache_d;
      word_q       <= word_d;
      last_write_q <= last_write_d;
      proto_err_q  <= proto_err_d;
    end
  end

  bsg_cache_axi_mem_array #(
    .els_p       (num_cache_p * mem_els_per_cache_p),
    .width_p     (axi_data_width_p),
    .idx_width_p (idx_width_lp)
  ) array_u (
    .clk_i    (clk_i),
    .w_v_i    (w_fire),
    .w_idx_i  (mem_idx),
    .w_data_i (axi_wdata_i),
    .w_mask_i (axi_wstrb_i),
    .r_idx_i  (mem_idx),
    .r_data_o (mem_rdata)
  );

  // Handshake: a beat transfers on any rising edge where valid && ready.
  assign axi_awready_o = aw_grant;
  assign axi_arready_o = ar_grant;
  assign axi_wready_o  = (state_q == WDATA);
  assign axi_bvalid_o  = (state_q == WRESP);
  assign axi_bid_o     = id_q;
  assign axi_bresp_o   = axi_resp_okay;
  assign axi_rvalid_o  = (state_q == RDATA);
  assign axi_rid_o     = id_q;
  assign axi_rdata_o   = axi_rvalid_o ? mem_rdata : '0;
  assign axi_rlast_o   = axi_rvalid_o && is_last;
  assign axi_rresp_o   = axi_resp_okay;
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_bsg_cache_axi_mem.sv
// Directed bench for bsg_cache_axi_mem: write/read bursts, byte masks,
// arbitration, backpressure, region wrap, protocol errors and reset abort.
module tb_bsg_cache_axi_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic        awcache = 1'b0, arcache = 1'b0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        awready, arready, wready, bvalid, rvalid, rlast, proto_err;
  logic [5:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wd [4];
  logic [3:0]  ws [4];
  logic [31:0] rd [4];
  logic        rl [4];
  logic [5:0]  rid_got, bid_got;
  logic [1:0]  bresp_got;

  bsg_cache_axi_mem #(
    .addr_width_p(32), .num_cache_p(2), .axi_id_width_p(6),
    .axi_data_width_p(32), .axi_burst_len_p(4), .mem_els_per_cache_p(64)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .axi_awid_i(awid), .axi_awaddr_addr_i(awaddr), .axi_awaddr_cache_id_i(awcache),
    .axi_awlen_i(awlen), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_addr_i(araddr), .axi_araddr_cache_id_i(arcache),
    .axi_arlen_i(arlen), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  // ---------------- clock/reset ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [5:0] id, input logic c, input logic [31:0] a,
                         input logic [7:0] len, output bit ok);
    awid = id; awcache = c; awaddr = a; awlen = len; awvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [5:0] id, input logic c, input logic [31:0] a,
                         input logic [7:0] len, output bit ok);
    arid = id; arcache = c; araddr = a; arlen = len; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                        output bit ok);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(output logic [5:0] id, output logic [1:0] resp, output bit ok);
    bready = 1'b1; ok = 1'b0; id = '0; resp = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; id = bid; resp = bresp; break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic r_take(output logic [31:0] d, output logic last, output logic [5:0] id,
                        output bit ok);
    rready = 1'b1; ok = 1'b0; d = '0; last = 1'b0; id = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; d = rdata; last = rlast; id = rid; break; end
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] id, input logic c, input logic [31:0] a,
                             output bit ok);
    bit o;
    aw_send(id, c, a, 8'd3, ok);
    for (int i = 0; i < 4; i++) begin
      w_beat(wd[i], ws[i], (i == 3), o);
      ok = ok & o;
    end
    b_take(bid_got, bresp_got, o);
    ok = ok & o;
  endtask

  task automatic read_burst(input logic [5:0] id, input logic c, input logic [31:0] a,
                            output bit ok);
    bit o;
    ar_send(id, c, a, 8'd3, ok);
    for (int i = 0; i < 4; i++) begin
      r_take(rd[i], rl[i], rid_got, o);
      ok = ok & o;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; awvalid = 1'b1; arvalid = 1'b1;
    #1;
    n_checks++; if ({awready, arready} !== 2'b00) $display("FAIL reset_readys: got %b expected 00", {awready, arready}); else n_pass++;
    n_checks++; if ({wready, bvalid, rvalid, rlast, proto_err} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {wready, bvalid, rvalid, rlast, proto_err}); else n_pass++;
    n_checks++; if ({bid, rid, rdata} !== 44'h0) $display("FAIL reset_id_data: got %h expected 0", {bid, rid, rdata}); else n_pass++;
    do_reset();
  endtask

  task automatic test_write_read();
    bit ok, o;
    aw_send(6'd5, 1'b1, 32'h40, 8'd3, ok);
    n_checks++; if (!ok) $display("FAIL wr_aw_timeout: got no awready expected awready"); else n_pass++;
    n_checks++; if (wready !== 1'b1) $display("FAIL wr_wready_latency: got %b expected 1", wready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      w_beat(32'hA0 + i, 4'hF, (i == 3), o);
      ok = ok & o;
    end
    n_checks++; if (bvalid !== 1'b1) $display("FAIL wr_b_latency: got %b expected 1", bvalid); else n_pass++;
    b_take(bid_got, bresp_got, o);
    ok = ok & o;
    n_checks++; if (!ok || bid_got !== 6'd5 || bresp_got !== 2'b00) $display("FAIL wr_bresp: got ok=%0d id=%0d resp=%0d expected ok=1 id=5 resp=0", ok, bid_got, bresp_got); else n_pass++;
    ar_send(6'd9, 1'b1, 32'h40, 8'd3, ok);
    n_checks++; if (!ok || rvalid !== 1'b1 || rdata !== 32'hA0) $display("FAIL rd_first_beat: got ok=%0d rvalid=%b rdata=%h expected 1 1 a0", ok, rvalid, rdata); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      r_take(rd[i], rl[i], rid_got, o);
      n_checks++; if (!o || rd[i] !== 32'hA0 + i || rl[i] !== (i == 3) || rid_got !== 6'd9 || rresp !== 2'b00)
        $display("FAIL rd_beat%0d: got data=%h last=%b id=%0d expected data=%h last=%b id=9", i, rd[i], rl[i], rid_got, 32'hA0 + i, (i == 3)); else n_pass++;
    end
  endtask

  task automatic test_byte_mask();
    bit ok;
    wd = '{32'hFFFF_FFFF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(6'd1, 1'b0, 32'h20, ok);
    wd = '{32'h1234_5678, 32'h0, 32'h0, 32'h0};
    ws = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
    write_burst(6'd2, 1'b0, 32'h20, ok);
    read_burst(6'd3, 1'b0, 32'h20, ok);
    n_checks++; if (!ok || rd[0] !== 32'hFFFF_5678) $display("FAIL mask_beat0: got %h expected ffff5678", rd[0]); else n_pass++;
    n_checks++; if (rd[1] !== 32'h2222_2222 || rd[3] !== 32'h4444_4444) $display("FAIL mask_zero_strb: got %h %h expected 22222222 44444444", rd[1], rd[3]); else n_pass++;
  endtask

  task automatic test_arbitration();
    bit ok, o;
    do_reset();
    awid = 6'd1; awcache = 1'b0; awaddr = 32'h80; awlen = 8'd3; awvalid = 1'b1;
    arid = 6'd2; arcache = 1'b0; araddr = 32'h80; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    n_checks++; if ({awready, arready} !== 2'b10) $display("FAIL arb_first_conflict: got aw/ar=%b expected 10", {awready, arready}); else n_pass++;
    @(posedge clk); #1;
    awvalid = 1'b0;
    n_checks++; if (arready !== 1'b0) $display("FAIL arb_ar_busy: got %b expected 0", arready); else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_beat(32'h11 + i, 4'hF, (i == 3), o);
      ok = ok & o;
    end
    b_take(bid_got, bresp_got, o);
    ok = ok & o;
    awid = 6'd3; awvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (!ok || {awready, arready} !== 2'b01) $display("FAIL arb_second_conflict: got ok=%0d aw/ar=%b expected 01", ok, {awready, arready}); else n_pass++;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_take(rd[i], rl[i], rid_got, o);
      n_checks++; if (!o || rd[i] !== 32'h11 + i || rid_got !== 6'd2) $display("FAIL arb_read%0d: got %h id=%0d expected %h id=2", i, rd[i], rid_got, 32'h11 + i); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (awready !== 1'b1) $display("FAIL arb_write_after_read: got %b expected 1", awready); else n_pass++;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) w_beat(32'h55, 4'hF, (i == 3), o);
    b_take(bid_got, bresp_got, o);
    n_checks++; if (!o || bid_got !== 6'd3) $display("FAIL arb_third_bid: got %0d expected 3", bid_got); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok, o;
    bit [6:0] pat;
    logic [31:0] prev_d, cur_d;
    logic prev_l, cur_l, cur_v, prev_acc;
    int ng;
    aw_send(6'd7, 1'b0, 32'hC0, 8'd3, ok);
    for (int i = 0; i < 4; i++) w_beat(32'hB0 + i, 4'hF, (i == 3), o);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bvalid !== 1'b1 || bid !== 6'd7) $display("FAIL bp_bvalid_hold%0d: got bvalid=%b bid=%0d expected 1 7", i, bvalid, bid); else n_pass++;
      @(posedge clk); #1;
    end
    b_take(bid_got, bresp_got, o);
    n_checks++; if (!o || bid_got !== 6'd7) $display("FAIL bp_bid: got %0d expected 7", bid_got); else n_pass++;
    ar_send(6'd8, 1'b0, 32'hC0, 8'd3, ok);
    pat = 7'b1101001;
    ng = 0; prev_acc = 1'b1; prev_d = '0; prev_l = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rready = pat[i];
      @(negedge clk);
      cur_d = rdata; cur_l = rlast; cur_v = rvalid;
      if (!prev_acc) begin
        n_checks++; if (cur_d !== prev_d || cur_l !== prev_l) $display("FAIL bp_r_stable%0d: got %h/%b expected %h/%b", i, cur_d, cur_l, prev_d, prev_l); else n_pass++;
      end
      if (cur_v && pat[i]) begin
        if (ng < 4) begin
          n_checks++; if (cur_d !== 32'hB0 + ng || cur_l !== (ng == 3)) $display("FAIL bp_r_beat%0d: got %h/%b expected %h/%b", ng, cur_d, cur_l, 32'hB0 + ng, (ng == 3)); else n_pass++;
        end
        ng++;
      end
      prev_acc = cur_v && pat[i]; prev_d = cur_d; prev_l = cur_l;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    n_checks++; if (ng !== 4 || rvalid !== 1'b0) $display("FAIL bp_beat_count: got %0d rvalid=%b expected 4 0", ng, rvalid); else n_pass++;
  endtask

  task automatic test_region_wrap();
    bit ok;
    wd = '{32'hC0, 32'hC1, 32'hC2, 32'hC3}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(6'd10, 1'b1, 32'h0, ok);
    wd = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    write_burst(6'd11, 1'b0, 32'hF8, ok);
    read_burst(6'd12, 1'b0, 32'h0, ok);
    n_checks++; if (!ok || rd[0] !== 32'hD2 || rd[1] !== 32'hD3) $display("FAIL wrap_low_words: got %h %h expected d2 d3", rd[0], rd[1]); else n_pass++;
    read_burst(6'd12, 1'b0, 32'hF8, ok);
    n_checks++; if (!ok || rd[0] !== 32'hD0 || rd[3] !== 32'hD3) $display("FAIL wrap_read: got %h %h expected d0 d3", rd[0], rd[3]); else n_pass++;
    read_burst(6'd12, 1'b1, 32'h0, ok);
    n_checks++; if (!ok || rd[0] !== 32'hC0 || rd[1] !== 32'hC1) $display("FAIL wrap_neighbour: got %h %h expected c0 c1", rd[0], rd[1]); else n_pass++;
  endtask

  task automatic test_proto_err();
    bit ok, o;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL perr_clean: got %b expected 0", proto_err); else n_pass++;
    aw_send(6'd12, 1'b0, 32'h60, 8'd3, ok);
    for (int i = 0; i < 4; i++) w_beat(32'hE0 + i, 4'hF, (i == 1), o);
    n_checks++; if (bvalid !== 1'b1) $display("FAIL perr_len_driven_b: got %b expected 1", bvalid); else n_pass++;
    b_take(bid_got, bresp_got, o);
    n_checks++; if (proto_err !== 1'b1) $display("FAIL perr_wlast: got %b expected 1", proto_err); else n_pass++;
    wd = '{32'hF0, 32'hF1, 32'hF2, 32'hF3}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(6'd13, 1'b0, 32'h60, ok);
    n_checks++; if (proto_err !== 1'b1) $display("FAIL perr_sticky: got %b expected 1", proto_err); else n_pass++;
    do_reset();
    n_checks++; if (proto_err !== 1'b0) $display("FAIL perr_reset: got %b expected 0", proto_err); else n_pass++;
    ar_send(6'd13, 1'b0, 32'h60, 8'd1, ok);
    r_take(rd[0], rl[0], rid_got, o);
    r_take(rd[1], rl[1], rid_got, o);
    n_checks++; if (rd[0] !== 32'hF0 || rl[0] !== 1'b0 || rd[1] !== 32'hF1 || rl[1] !== 1'b1) $display("FAIL perr_short_burst: got %h/%b %h/%b expected f0/0 f1/1", rd[0], rl[0], rd[1], rl[1]); else n_pass++;
    n_checks++; if (proto_err !== 1'b1 || rvalid !== 1'b0) $display("FAIL perr_len: got err=%b rvalid=%b expected 1 0", proto_err, rvalid); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit ok, o;
    ar_send(6'd14, 1'b0, 32'h60, 8'd3, ok);
    r_take(rd[0], rl[0], rid_got, o);
    n_checks++; if (!o || rvalid !== 1'b1 || rdata !== 32'hF1) $display("FAIL rst_mid_pre: got rvalid=%b rdata=%h expected 1 f1", rvalid, rdata); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0 || rlast !== 1'b0) $display("FAIL rst_mid_abort: got rvalid=%b rdata=%h expected 0 0", rvalid, rdata); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    awid = 6'd1; awcache = 1'b0; awaddr = 32'h0; awlen = 8'd3; awvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (awready !== 1'b1 || rvalid !== 1'b0) $display("FAIL rst_mid_idle: got awready=%b rvalid=%b expected 1 0", awready, rvalid); else n_pass++;
    #1;
    awvalid = 1'b0;
    @(negedge clk);
    n_checks++; if ({rvalid, bvalid, wready} !== 3'b000) $display("FAIL rst_mid_quiet: got %b expected 000", {rvalid, bvalid, wready}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_arbitration();
    test_backpressure();
    test_region_wrap();
    test_proto_err();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
